// File: rtl/log_pkg.sv
// Shared definitions for the natural-logarithm unit.
// Contents: FSM state type, datapath width constants, ln(1+2^-k) table.
// The table is generated for GUARD = 4 (F = 20); entries are ln(1+2^-k)*2^20 rounded.
package log_pkg;

    localparam int GUARD  = 4;
    localparam int N_ITER = 17;
    localparam int F      = 16 + GUARD;
    localparam int LN_W   = F + 1;    // 1.F table entries
    localparam int K_W    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LN_W-1:0] LN_TABLE [0:16] = '{
        21'd726817,   // ln 2
        21'd425161,   // ln 1.5
        21'd233983,
        21'd123504,
        21'd63570,
        21'd32266,
        21'd16257,
        21'd8160,
        21'd4088,
        21'd2046,
        21'd1024,
        21'd512,
        21'd256,
        21'd128,
        21'd64,
        21'd32,
        21'd16
    };

endpackage

// File: rtl/ln_rom.sv
// Combinational lookup k -> ln(1+2^-k) in 1.F fixed point.
// Ports: k (iteration index), val (table entry, 0 when k is past the table).
// Zero latency, no state.
module ln_rom
    import log_pkg::*;
(
    input  logic [K_W-1:0]  k,
    output logic [LN_W-1:0] val
);

    always_comb begin
        val = '0;
        if (k <= K_W'(16)) begin
            val = LN_TABLE[k];
        end
    end

endmodule

// File: rtl/logarithm.sv
// Iterative natural logarithm of y in [1,4) by shift-and-add normalisation.
// Ports: clk/rst, start + intpart/fracpart (2.16 input), done/busy/err, lnint/lnfrac (1.16 result).
// Latency: 17 iterations after accept, done one cycle later; start ignored while busy.
module logarithm #(
    parameter int N_ITER = 17,
    parameter int GUARD  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  intpart,
    input  logic [15:0] fracpart,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic        lnint,
    output logic [15:0] lnfrac
);

    import log_pkg::*;

    // GUARD must match the package value: the ln table is built for that fraction width.
    localparam int FW = 16 + GUARD;

    state_t            state;
    state_t            state_nxt;

    logic [FW+1:0]     yr;       // 2.F target
    logic [FW+2:0]     p;        // 3.F running product
    logic [FW:0]       acc;      // 1.F running logarithm
    logic [K_W-1:0]    k;
    logic              err_q;
    logic [16:0]       res_q;

    logic [LN_W-1:0]   ln_k;
    logic [FW+2:0]     t;
    logic              take;
    logic [FW:0]       acc_next;
    logic              last;

    ln_rom u_rom (
        .k   (k),
        .val (ln_k)
    );

    // p < 4 and p >> k <= p, so t < 8 always fits the 3.F product width.
    assign t        = p + (p >> k);
    assign take     = (t <= {1'b0, yr});
    assign acc_next = take ? (acc + ln_k) : acc;
    assign last     = (k == K_W'(N_ITER - 1));

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (intpart != 2'd0) ? ITER : DONE;
                end
            end
            ITER: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            yr    <= '0;
            p     <= '0;
            acc   <= '0;
            k     <= '0;
            err_q <= 1'b0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (intpart != 2'd0) begin
                            yr  <= {intpart, fracpart, {GUARD{1'b0}}};
                            p   <= (FW+3)'(1) << FW;
                            acc <= '0;
                            k   <= '0;
                        end else begin
                            // y < 1: ln would be negative, outside the result format
                            err_q <= 1'b1;
                            res_q <= '0;
                        end
                    end
                end
                ITER: begin
                    if (take) begin
                        p <= t;
                    end
                    acc <= acc_next;
                    k   <= k + K_W'(1);
                    if (last) begin
                        // Drop the guard bits by truncation
                        res_q <= 17'(acc_next >> GUARD);
                        err_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign err    = err_q;
    assign lnint  = res_q[16];
    assign lnfrac = res_q[15:0];

endmodule

// File: tb/tb_logarithm.sv
module tb_logarithm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  intpart;
    logic [15:0] fracpart;
    logic        done;
    logic        busy;
    logic        err;
    logic        lnint;
    logic [15:0] lnfrac;

    always #5 clk = ~clk;

    logarithm dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .intpart  (intpart),
        .fracpart (fracpart),
        .done     (done),
        .busy     (busy),
        .err      (err),
        .lnint    (lnint),
        .lnfrac   (lnfrac)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_done   = 0;
    bit prev_done = 1'b0;

    // Expected completions: error flag, input value, cycle count at the accepting edge
    bit  q_err[$];
    real q_y[$];
    int  q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input string act, input string req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, act, req);
        end
    endtask

    function automatic int result();
        return int'({lnint, lnfrac});
    endfunction

    task automatic chk_ln(input string name, input real y);
        real r;
        real d;
        r = $ln(y) * 65536.0;
        d = real'(result()) - r;
        chk(name, (d <= 2.0) && (d >= -2.0), $sformatf("%0d", result()), $sformatf("%.2f +/-2", r));
    endtask

    // Compare process: every done pulse is matched against the oldest expectation
    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                n_done++;
                chk("done_one_cycle", !prev_done, "done high twice in a row", "single-cycle pulse");
                if (q_err.size() == 0) begin
                    chk("unexpected_done", 1'b0, "done", "no done");
                end else begin
                    bit  e_err;
                    real e_y;
                    int  e_c;
                    e_err = q_err.pop_front();
                    e_y   = q_y.pop_front();
                    e_c   = q_cyc.pop_front();
                    chk("latency", (cyc - e_c) == (e_err ? 0 : 17),
                        $sformatf("%0d", cyc - e_c), $sformatf("%0d", e_err ? 0 : 17));
                    chk("err_flag", err == e_err, $sformatf("%0b", err), $sformatf("%0b", e_err));
                    if (e_err) begin
                        chk("err_result", result() == 0, $sformatf("%0d", result()), "0");
                    end else begin
                        chk_ln("ln_value", e_y);
                    end
                end
            end
            prev_done = done;
        end
    end

    // Present one request at a negedge, return at the negedge after acceptance
    task automatic accept_op(input logic [1:0] ip, input logic [15:0] fp);
        int w;
        w = 0;
        while ((busy || done) && w < 50) begin
            @(negedge clk);
            w++;
        end
        start    = 1'b1;
        intpart  = ip;
        fracpart = fp;
        @(posedge clk);
        #1;
        q_err.push_back(ip == 2'd0);
        q_y.push_back(real'(ip) + real'(fp) / 65536.0);
        q_cyc.push_back(cyc);
        start    = 1'b0;
        intpart  = 2'($urandom);
        fracpart = 16'($urandom);
        @(negedge clk);
        chk("busy_after_accept", busy == 1'b1, $sformatf("%0b", busy), "1");
    endtask

    task automatic wait_all();
        int w;
        w = 0;
        while (q_err.size() != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("done_arrived", q_err.size() == 0, $sformatf("%0d pending", q_err.size()), "0 pending");
        q_err.delete();
        q_y.delete();
        q_cyc.delete();
        @(negedge clk);
    endtask

    task automatic run_op(input logic [1:0] ip, input logic [15:0] fp);
        accept_op(ip, fp);
        wait_all();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_done"},   done == 1'b0,    $sformatf("%0b", done),   "0");
        chk({tag, "_busy"},   busy == 1'b0,    $sformatf("%0b", busy),   "0");
        chk({tag, "_err"},    err == 1'b0,     $sformatf("%0b", err),    "0");
        chk({tag, "_lnint"},  lnint == 1'b0,   $sformatf("%0b", lnint),  "0");
        chk({tag, "_lnfrac"}, lnfrac == 16'd0, $sformatf("%0d", lnfrac), "0");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst      = 1'b1;
        start    = 1'b0;
        intpart  = 2'd0;
        fracpart = 16'd0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        // rst wins over start
        start   = 1'b1;
        intpart = 2'd2;
        @(negedge clk);
        chk("rst_beats_start", busy == 1'b0, $sformatf("%0b", busy), "0");
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        // Hand-computed pins
        run_op(2'd1, 16'h0000);
        chk("y1_result", result() <= 2, $sformatf("%0d", result()), "0 +/-2");
        run_op(2'd2, 16'h0000);
        chk("y2_result", (result() >= 45424) && (result() <= 45428), $sformatf("%0d", result()), "45426 +/-2");
        run_op(2'd3, 16'hFFFF);
        chk("y4_lnint", lnint == 1'b1, $sformatf("%0b", lnint), "1");
        chk("y4_lnfrac", (lnfrac >= 16'd25314) && (lnfrac <= 16'd25318), $sformatf("%0d", lnfrac), "25316 +/-2");
        // exp(10 * 2^-16) in 2.16 is 1 + 10/65536
        run_op(2'd1, 16'd10);
        chk("round_trip", (result() >= 7) && (result() <= 13), $sformatf("%0d", result()), "10 +/-3");
        run_op(2'd0, 16'h8000);
        chk("domain_err", err == 1'b1, $sformatf("%0b", err), "1");
        chk("domain_res", result() == 0, $sformatf("%0d", result()), "0");
        run_op(2'd1, 16'h8000);
        chk("err_clears", err == 1'b0, $sformatf("%0b", err), "0");

        // Randomised operations, including back-to-back starts and domain errors
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), 16'($urandom));
        end

        // A second start mid-iteration is ignored
        d0 = n_done;
        accept_op(2'd3, 16'h4000);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        intpart  = 2'd1;
        fracpart = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        wait_all();
        repeat (25) @(negedge clk);
        chk("ignored_start", n_done == d0 + 1, $sformatf("%0d dones", n_done - d0), "1 done");

        // Reset mid-operation aborts with no done
        run_op(2'd3, 16'hC000);
        accept_op(2'd2, 16'h1000);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        q_err.delete();
        q_y.delete();
        q_cyc.delete();
        @(negedge clk);
        rst = 1'b0;
        chk_zero_outputs("abort");
        d0 = n_done;
        repeat (25) @(negedge clk);
        chk("abort_no_done", n_done == d0, $sformatf("%0d dones", n_done - d0), "0 dones");

        // Fresh start after the abort
        run_op(2'd2, 16'h8000);
        chk("fresh_err", err == 1'b0, $sformatf("%0b", err), "0");
        chk_ln("fresh_value", 2.5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
